fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core index used only in trace/debug output.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 SHALL have parameter MASK_W, default 32, execution mask width.
REQ-004 SHALL have parameter HALT_OPCODE, default 8'hFF, opcode value (insn[7:0]) treated as HALT.
REQ-005 Ports (name direction width meaning), one clock, reset synchronous active-low:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  synchronous active-low reset
  mem_req_valid  out  1  instruction read request
  mem_req_addr  out  64  read address (PC)
  mem_req_ready  in  1  memory accepts request
  mem_rsp_valid  in  1  read data returned
  mem_rsp_data  in  32  instruction word
  fb_valid  out  1  fetch-to-decode packet pending (decode sees bus busy)
  fb_pc  out  64  packet PC
  fb_insn  out  32  packet instruction
  fb_exec_mask  out  MASK_W  packet execution mask
  fb_ready  in  1  decode takes packet this cycle
  redir_valid  in  1  execute-stage redirect (jump taken / restore PC)
  redir_pc  in  64  new PC
  redir_mask  in  MASK_W  new execution mask

Function
REQ-006 FSM states SHALL be REQ, WAIT_RSP, SEND, STOPPED.
REQ-007 REQ: mem_req_valid=1, mem_req_addr=pc; on mem_req_ready -> WAIT_RSP next cycle.
REQ-008 WAIT_RSP: on mem_rsp_valid, capture fb_insn=mem_rsp_data, fb_pc=pc, fb_exec_mask=mask; -> SEND.
REQ-009 SEND: fb_valid=1, fb_pc/fb_insn/fb_exec_mask SHALL be held stable until fb_valid&&fb_ready.
REQ-010 On SEND handshake, pc SHALL become pc+4 (64-bit wrap modulo 2^64) and FSM -> REQ next cycle; min throughput one packet per 3 cycles with zero-latency memory.
REQ-011 Redirect in REQ: pc<=redir_pc, mask<=redir_mask; any request accepted same cycle SHALL be treated as stale.
REQ-012 Redirect in WAIT_RSP: pc/mask updated, one pending response SHALL be dropped (drop flag), then -> REQ; if mem_rsp_valid arrives the same cycle, it SHALL be dropped and FSM -> REQ.
REQ-013 Redirect in SEND: fb_valid SHALL deassert next cycle; if fb_ready is high the same cycle, the handshake counts as complete; either way pc<=redir_pc (no +4), -> REQ.
REQ-014 Redirect in STOPPED: pc/mask updated, -> REQ.
REQ-015 Only one outstanding memory request SHALL exist at any time.
REQ-016 mem_rsp_valid in REQ or SEND (unexpected) SHALL be ignored.

Reset
REQ-017 While rst_n=0 at clk edge: state=REQ, pc=RESET_PC, mask=all ones, drop flag=0, fb_valid=0, fb_pc=0, fb_insn=0, fb_exec_mask=0, mem_req_valid=0 (asserted first cycle after release).
REQ-018 Reset mid-request or mid-SEND SHALL abandon the transaction; a late response after reset SHALL be ignored.

Configuration
REQ-019 Macro FETCH_HALT_STOP_EN defined: on SEND handshake with fb_insn[7:0]==HALT_OPCODE, FSM -> STOPPED (no requests) until redirect.
REQ-020 Macro undefined: HALT packets SHALL be sent like any other and fetching continues at pc+4; STOPPED unreachable.

Verification
REQ-021 Reset release, RESET_PC=0x100, memory ready/1-cycle rsp 0x11223344, fb_ready=1 -> packets pc 0x100, 0x104, 0x108, mask all ones.
REQ-022 fb_ready=0 for 10 cycles in SEND -> fb_valid held, fb_pc/fb_insn unchanged, no new mem_req_valid.
REQ-023 redir_valid with redir_pc=0x400, mask=0x0F during WAIT_RSP -> old response dropped, next packet pc 0x400, mask 0x0F.
REQ-024 redir_valid and fb_ready same cycle in SEND at pc 0x200, redir_pc 0x800 -> next request address 0x800, not 0x204.
REQ-025 With FETCH_HALT_STOP_EN, insn 0x000000FF sent -> no mem_req_valid until redirect to 0x40, then fetch 0x40; without macro -> fetch continues at pc+4.
REQ-026 rst_n low for one cycle during WAIT_RSP, late response arrives -> ignored, first packet pc=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: single-issue fetch, one memory request in flight,
// one-entry packet register toward decode, redirect from execute.
// Ports: clk, rst_n (sync, active-low); mem_req_* / mem_rsp_*
// to instruction memory; fb_* packet to decode; redir_* from execute.
// Option: `define FETCH_HALT_STOP_EN parks fetch after a HALT packet.
module fetch_stage #(
  parameter int          CORE_ID     = 0,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MASK_W      = 32,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req_valid,
  output logic [63:0]       mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              fb_valid,
  output logic [63:0]       fb_pc,
  output logic [31:0]       fb_insn,
  output logic [MASK_W-1:0] fb_exec_mask,
  input  logic              fb_ready,
  input  logic              redir_valid,
  input  logic [63:0]       redir_pc,
  input  logic [MASK_W-1:0] redir_mask
);

  typedef enum logic [1:0] {
    REQ,
    WAIT_RSP,
    SEND,
    STOPPED
  } state_t;

  state_t            state, state_nx;
  logic [63:0]       pc, pc_nx;
  logic [MASK_W-1:0] mask, mask_nx;
  logic              drop, drop_nx;
  logic              cap;
  logic              acc;
  logic              hs;
  logic              is_halt;
  logic              unused_cfg;

  // CORE_ID only tags debug output; tie it off here.
  assign unused_cfg = (CORE_ID < 0) ^ (HALT_OPCODE == 8'h00);

  // While a stale response is still owed, hold off the next
  // request so only one read is ever outstanding.
  assign mem_req_valid = rst_n && (state == REQ) && !drop;
  assign mem_req_addr  = pc;
  assign fb_valid      = (state == SEND);
  assign acc           = mem_req_valid && mem_req_ready;
  assign hs            = fb_valid && fb_ready;

`ifdef FETCH_HALT_STOP_EN
  assign is_halt = (fb_insn[7:0] == HALT_OPCODE);
`else
  assign is_halt = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    mask_nx  = mask;
    drop_nx  = drop;
    cap      = 1'b0;
    if (drop && mem_rsp_valid) drop_nx = 1'b0;
    unique case (state)
      REQ: begin
        if (redir_valid) begin
          pc_nx   = redir_pc;
          mask_nx = redir_mask;
          if (acc) drop_nx = 1'b1;
        end else if (acc) begin
          state_nx = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (redir_valid) begin
          pc_nx    = redir_pc;
          mask_nx  = redir_mask;
          drop_nx  = !mem_rsp_valid;
          state_nx = REQ;
        end else if (mem_rsp_valid) begin
          cap      = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (redir_valid) begin
          pc_nx    = redir_pc;
          mask_nx  = redir_mask;
          state_nx = REQ;
        end else if (hs) begin
          pc_nx    = pc + 64'd4;
          state_nx = is_halt ? STOPPED : REQ;
        end
      end
      STOPPED: begin
        if (redir_valid) begin
          pc_nx    = redir_pc;
          mask_nx  = redir_mask;
          state_nx = REQ;
        end
      end
      default: state_nx = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= REQ;
      pc           <= RESET_PC;
      mask         <= '1;
      drop         <= 1'b0;
      fb_pc        <= '0;
      fb_insn      <= '0;
      fb_exec_mask <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      mask  <= mask_nx;
      drop  <= drop_nx;
      if (cap) begin
        fb_pc        <= pc;
        fb_insn      <= mem_rsp_data;
        fb_exec_mask <= mask;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + random bench for fetch_stage with a
// transaction-level model (packet stream = memory[pc], pc+4/redirect).
module tb_fetch_stage;

  localparam logic [63:0] RPC = 64'h100;
  localparam int          MW  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req_valid;
  logic [63:0]   mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          fb_valid;
  logic [63:0]   fb_pc;
  logic [31:0]   fb_insn;
  logic [MW-1:0] fb_exec_mask;
  logic          fb_ready;
  logic          redir_valid;
  logic [63:0]   redir_pc;
  logic [MW-1:0] redir_mask;

  fetch_stage #(
    .CORE_ID(0),
    .RESET_PC(RPC),
    .MASK_W(MW),
    .HALT_OPCODE(8'hFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .fb_valid(fb_valid),
    .fb_pc(fb_pc),
    .fb_insn(fb_insn),
    .fb_exec_mask(fb_exec_mask),
    .fb_ready(fb_ready),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc),
    .redir_mask(redir_mask)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // memory model knobs and state
  int          rdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          mode_const = 1'b1;
  logic [31:0] mem_const = 32'h11223344;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_dq;
  int          mem_lat = 0;
  bit          ev_acc = 1'b0;

  // reference model of the packet stream
  logic [63:0]   exp_pc = RPC;
  logic [MW-1:0] exp_mask = '1;
  int            npk = 0;
  logic [63:0]   pk_pc[$];
  logic [MW-1:0] pk_mask[$];
  bit            hold = 1'b0;
  logic [63:0]   h_pc;
  logic [31:0]   h_insn;
  logic [MW-1:0] h_mask;

  int          n;
  int          n0;
  logic [63:0] sp;
  logic [31:0] si;
  logic [63:0] hp;

  function automatic logic [31:0] fmem(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] exp_insn(input logic [63:0] a);
    return mode_const ? mem_const : fmem(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst_n) begin
      exp_pc   = RPC;
      exp_mask = '1;
      hold     = 1'b0;
      ev_acc   = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", fb_valid, 1);
        chk("hold_pc", fb_pc, h_pc);
        chk("hold_insn", fb_insn, h_insn);
        chk("hold_mask", fb_exec_mask, h_mask);
      end
      ev_acc = mem_req_valid && mem_req_ready;
      if (ev_acc)
        chk("one_outstanding", mem_busy && !mem_rsp_valid, 0);
      if (fb_valid && fb_ready) begin
        chk("pkt_pc", fb_pc, exp_pc);
        chk("pkt_insn", fb_insn, exp_insn(exp_pc));
        chk("pkt_mask", fb_exec_mask, exp_mask);
        pk_pc.push_back(fb_pc);
        pk_mask.push_back(fb_exec_mask);
        npk++;
        if (!redir_valid) exp_pc = exp_pc + 64'd4;
      end
      if (redir_valid) begin
        exp_pc   = redir_pc;
        exp_mask = redir_mask;
      end
      hold   = fb_valid && !fb_ready && !redir_valid;
      h_pc   = fb_pc;
      h_insn = fb_insn;
      h_mask = fb_exec_mask;
    end
    @(posedge clk);
    #1;
    if (mem_rsp_valid) mem_busy = 1'b0;
    if (ev_acc) begin
      mem_busy = 1'b1;
      mem_dq   = mode_const ? mem_const : fmem(mem_req_addr);
      mem_lat  = $urandom_range(lat_max, lat_min);
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (mem_busy) begin
      mem_lat--;
      if (mem_lat == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_dq;
      end
    end
    mem_req_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic drain();
    rdy_pct = 0;
    repeat (8) cycle();
  endtask

  initial begin
    rst_n         = 1'b0;
    fb_ready      = 1'b1;
    redir_valid   = 1'b0;
    redir_pc      = '0;
    redir_mask    = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    // reset state
    repeat (3) cycle();
    chk("rst_req", mem_req_valid, 0);
    chk("rst_fbv", fb_valid, 0);
    chk("rst_fbpc", fb_pc, 0);
    chk("rst_insn", fb_insn, 0);
    chk("rst_mask", fb_exec_mask, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_req", mem_req_valid, 1);
    chk("rel_addr", mem_req_addr, RPC);

    // streaming at full rate: 3 packets in 9 cycles
    repeat (9) cycle();
    chk("thru_npk", npk, 3);
    chk("s_pc0", pk_pc[0], 64'h100);
    chk("s_pc1", pk_pc[1], 64'h104);
    chk("s_pc2", pk_pc[2], 64'h108);
    chk("s_mask", pk_mask[0], 64'hFFFF_FFFF);

    // decode stall for 10 cycles
    fb_ready = 1'b0;
    n = 0;
    while (!fb_valid && n < 40) begin cycle(); n++; end
    chk("t_stall", n < 40, 1);
    sp = fb_pc;
    si = fb_insn;
    repeat (10) begin
      cycle();
      chk("stall_noreq", mem_req_valid, 0);
    end
    chk("stall_v", fb_valid, 1);
    chk("stall_pc", fb_pc, sp);
    chk("stall_insn", fb_insn, si);
    fb_ready = 1'b1;
    cycle();

    // redirect during WAIT_RSP drops the old response
    drain();
    mode_const = 1'b0;
    rdy_pct = 100;
    lat_min = 3;
    lat_max = 3;
    n = 0;
    while (!(mem_busy && !mem_rsp_valid) && n < 40) begin
      cycle(); n++;
    end
    chk("t_wait", n < 40, 1);
    redir_valid = 1'b1;
    redir_pc    = 64'h400;
    redir_mask  = 32'h0F;
    n0 = npk;
    cycle();
    redir_valid = 1'b0;
    n = 0;
    while (npk == n0 && n < 40) begin cycle(); n++; end
    chk("t_wrd", n < 40, 1);
    chk("wrd_pc", pk_pc[$], 64'h400);
    chk("wrd_mask", pk_mask[$], 64'h0F);

    // redirect and handshake in the same SEND cycle
    lat_min = 1;
    lat_max = 1;
    fb_ready = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 64'h200;
    redir_mask  = '1;
    cycle();
    redir_valid = 1'b0;
    n = 0;
    while (!fb_valid && n < 40) begin cycle(); n++; end
    chk("t_send", n < 40, 1);
    chk("send_pc", fb_pc, 64'h200);
    n0 = npk;
    fb_ready    = 1'b1;
    redir_valid = 1'b1;
    redir_pc    = 64'h800;
    cycle();
    redir_valid = 1'b0;
    chk("rhs_cnt", npk, n0 + 1);
    n = 0;
    while (!mem_req_valid && n < 40) begin cycle(); n++; end
    chk("t_rhs", n < 40, 1);
    chk("rhs_addr", mem_req_addr, 64'h800);

    // HALT opcode handling
    drain();
    mode_const = 1'b1;
    mem_const  = 32'h0000_00FF;
    rdy_pct    = 100;
    n0 = npk;
    n = 0;
    while (npk == n0 && n < 40) begin cycle(); n++; end
    chk("t_halt", n < 40, 1);
    hp = pk_pc[$];
`ifdef FETCH_HALT_STOP_EN
    repeat (8) begin
      cycle();
      chk("halt_noreq", mem_req_valid, 0);
    end
    mode_const  = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 64'h40;
    redir_mask  = '1;
    cycle();
    redir_valid = 1'b0;
    chk("halt_req", mem_req_valid, 1);
    chk("halt_addr", mem_req_addr, 64'h40);
    n0 = npk;
    n = 0;
    while (npk == n0 && n < 40) begin cycle(); n++; end
    chk("t_h40", n < 40, 1);
    chk("h40_pc", pk_pc[$], 64'h40);
`else
    chk("halt_req", mem_req_valid, 1);
    chk("halt_addr", mem_req_addr, hp + 64'd4);
`endif
    drain();
    mode_const = 1'b0;

    // reset during WAIT_RSP with a late response
    rdy_pct = 100;
    lat_min = 2;
    lat_max = 2;
    n = 0;
    while (!(mem_busy && !mem_rsp_valid && mem_lat == 1) && n < 40)
    begin
      cycle(); n++;
    end
    chk("t_rw", n < 40, 1);
    rst_n = 1'b0;
    cycle();
    chk("rw_req", mem_req_valid, 0);
    chk("rw_late", mem_rsp_valid, 1);
    rst_n = 1'b1;
    n0 = npk;
    n = 0;
    while (npk == n0 && n < 40) begin cycle(); n++; end
    chk("t_rw2", n < 40, 1);
    chk("rw_pc", pk_pc[$], RPC);

    // random traffic against the model
    rdy_pct = 75;
    lat_min = 1;
    lat_max = 3;
    n0 = npk;
    repeat (600) begin
      fb_ready    = ($urandom_range(99) < 70);
      redir_valid = ($urandom_range(99) < 6);
      if ($urandom_range(3) == 0)
        redir_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      else
        redir_pc = {$urandom(), $urandom()} & ~64'h3;
      redir_mask = $urandom();
      cycle();
    end
    redir_valid = 1'b0;
    chk("rand_prog", npk > n0 + 20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
